regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list SHALL be as follows:
  clk          in   1   rising-edge clock
  rst_n        in   1   async active-low reset
  req0_valid   in   1   ALU writeback request
  req0_reg     in   3   ALU destination register
  req0_data    in   16  ALU result
  req0_ready   out  1   ALU request accepted this cycle
  req1_valid   in   1   load-unit writeback request
  req1_reg     in   3   load destination register
  req1_data    in   16  load data
  req1_ready   out  1   load request accepted this cycle
  wb_stall     in   1   hold the register-file write port
  RegWrite     out  1   register-file write enable
  write_reg    out  3   register-file write address
  write_data   out  16  register-file write data
  wb_count     out  16  committed-write counter

Function
REQ-003 The block SHALL hold a single-entry output stage: out_valid, out_reg, out_data.
REQ-004 A commit SHALL occur on a rising edge where out_valid=1 and wb_stall=0.
REQ-005 RegWrite SHALL equal out_valid AND NOT wb_stall.
REQ-006 write_reg and write_data SHALL always equal out_reg and out_data.
REQ-007 can_accept SHALL equal NOT out_valid OR NOT wb_stall.
REQ-008 When can_accept=1 and at least one request is valid, the block SHALL grant exactly one requester.
REQ-009 reqN_ready SHALL be combinational and equal grant_N AND can_accept.
REQ-010 reqN_ready SHALL be 0 whenever reqN_valid=0.
REQ-011 A request SHALL transfer when valid=1 and ready=1 on the same edge; out_reg/out_data load from the granted requester and out_valid is set to 1.
REQ-012 Latency from accept to RegWrite=1 SHALL be exactly 1 cycle when wb_stall=0.
REQ-013 A commit without a simultaneous accept SHALL clear out_valid.
REQ-014 Commit and accept on the same edge SHALL give back-to-back writes at one per cycle.
REQ-015 While out_valid=1 and wb_stall=1, the output stage SHALL hold its contents and both ready outputs SHALL be 0.
REQ-016 Requesters SHALL keep valid, reg and data stable until accepted; the block need not check this.
REQ-017 Only one requester valid: that requester SHALL be granted regardless of arbitration state.
REQ-018 Both requesters targeting the same register: the accepted order defines the commit order, and the last commit wins.
REQ-019 Writes to register 0 SHALL be passed through unmodified.
REQ-020 wb_count SHALL increment by 1 on each commit and wrap from 0xFFFF to 0x0000.
REQ-021 wb_count SHALL be unaffected by wb_stall cycles without a commit.

Reset
REQ-022 On rst_n=0, the block SHALL asynchronously reset: out_valid=0, out_reg=0, out_data=0, wb_count=0, rr_last=1 (so requester 0 wins first).
REQ-023 During reset, RegWrite, req0_ready and req1_ready SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard the pending output entry; no write SHALL occur.
REQ-025 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro REGFILE_WB_ARB_RR_EN defined, arbitration SHALL be round-robin.
  - rr_last is a 1-bit register updated on each accept to the accepted requester index.
  - When both are valid, the requester not equal to rr_last is granted.
REQ-027 Without REGFILE_WB_ARB_RR_EN, arbitration SHALL be fixed priority.
  - Requester 1 (load) always wins ties.
  - rr_last is not implemented.

Verification
REQ-028 Single write: reset, then req0 {reg=4, data=20} for one cycle -> next cycle RegWrite=1, write_reg=4, write_data=20, wb_count=1.
REQ-029 Contention, RR_EN: both valid continuously (req0 reg=1 data=0x1111; req1 reg=2 data=0x2222) -> commits alternate 1,2,1,2 at one per cycle; first commit is reg 1. Without RR_EN -> req1 granted every cycle, req0_ready stays 0.
REQ-030 Stall: entry {reg=3, data=0xABCD} in output stage, wb_stall=1 for 3 cycles -> RegWrite=0, readies 0, contents held, wb_count unchanged; on release -> single commit of 0xABCD, wb_count+1.
REQ-031 Same-register race: req0 {5, 0x0005} and req1 {5, 0x0050} both valid, RR_EN -> commits 0x0005 then 0x0050; the register file reads 0x0050.
REQ-032 Reset mid-operation: accept {reg=6, data=0x7777}, assert rst_n=0 before the commit edge -> no RegWrite pulse, wb_count=0, out_valid=0.
REQ-033 Counter wrap: preload 0xFFFF commits -> next commit gives wb_count=0x0000.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a single-entry output stage.
// Define REGFILE_WB_ARB_RR_EN for round-robin arbitration; the default is load-first priority.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_reg,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_reg,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        wb_stall,
  output logic        RegWrite,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data,
  output logic [15:0] wb_count
);

  logic        out_valid;
  logic [2:0]  out_reg;
  logic [15:0] out_data;
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        commit;
  logic        accept;

  assign can_accept = !out_valid || !wb_stall;
  assign commit     = out_valid && !wb_stall;
  assign accept     = req0_ready || req1_ready;

`ifdef REGFILE_WB_ARB_RR_EN
  logic rr_last;

  // On a tie, the requester that did not win last time goes next.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || rr_last);
    grant1 = req1_valid && (!req0_valid || !rr_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= req1_ready;
    end
  end
`else
  always_comb begin
    grant1 = req1_valid;
    grant0 = req0_valid && !req1_valid;
  end
`endif

  // Readies are forced low while reset is held.
  assign req0_ready = rst_n && grant0 && can_accept;
  assign req1_ready = rst_n && grant1 && can_accept;

  assign RegWrite   = out_valid && !wb_stall;
  assign write_reg  = out_reg;
  assign write_data = out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_reg   <= 3'd0;
      out_data  <= 16'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_reg   <= req1_ready ? req1_reg : req0_reg;
      out_data  <= req1_ready ? req1_data : req0_data;
    end else if (commit) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= 16'd0;
    end else if (commit) begin
      wb_count <= wb_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Expectations cover both arbitration builds via REGFILE_WB_ARB_RR_EN.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid;
  logic [2:0]  req0_reg;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [2:0]  req1_reg;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        wb_stall;
  logic        RegWrite;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wb_stall   (wb_stall),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .wb_count   (wb_count)
  );

  typedef struct {
    logic        v0;
    logic [2:0]  g0;
    logic [15:0] d0;
    logic        v1;
    logic [2:0]  g1;
    logic [15:0] d1;
    logic        st;
    logic        r0;
    logic        r1;
    logic        rw;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    logic v0, logic [2:0] g0, logic [15:0] d0,
    logic v1, logic [2:0] g1, logic [15:0] d1, logic st,
    logic r0, logic r1, logic rw,
    logic [2:0] wr, logic [15:0] wd, logic [15:0] cnt);
    vec_t v;
    v.v0 = v0; v.g0 = g0; v.d0 = d0;
    v.v1 = v1; v.g1 = g1; v.d1 = d1; v.st = st;
    v.r0 = r0; v.r1 = r1; v.rw = rw;
    v.wr = wr; v.wd = wd; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(logic v0, logic [2:0] g0, logic [15:0] d0,
                       logic v1, logic [2:0] g1, logic [15:0] d1,
                       logic st);
    req0_valid = v0; req0_reg = g0; req0_data = d0;
    req1_valid = v1; req1_reg = g1; req1_data = d1;
    wb_stall   = st;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] commits[$];
  logic [15:0] rf[8];
  logic        a0;
  logic        a1;
  logic        e0;
  logic        e1;
  logic [2:0]  ewr;
  logic [15:0] ewd;
  logic [15:0] c0;
  logic [15:0] c1;

  initial begin
    tbl[0]  = mk(0,0,0,      0,0,0,      0, 0,0,0, 0,16'h0000,16'd0);
    tbl[1]  = mk(1,4,16'd20, 0,0,0,      0, 1,0,0, 0,16'h0000,16'd0);
    tbl[2]  = mk(0,0,0,      0,0,0,      0, 0,0,1, 4,16'd20,  16'd0);
    tbl[3]  = mk(0,0,0,      0,0,0,      0, 0,0,0, 4,16'd20,  16'd1);
    tbl[4]  = mk(1,3,16'hABCD,0,0,0,     0, 1,0,0, 4,16'd20,  16'd1);
    tbl[5]  = mk(0,0,0,      1,7,16'h0777,1, 0,0,0, 3,16'hABCD,16'd1);
    tbl[6]  = mk(0,0,0,      1,7,16'h0777,1, 0,0,0, 3,16'hABCD,16'd1);
    tbl[7]  = mk(0,0,0,      1,7,16'h0777,1, 0,0,0, 3,16'hABCD,16'd1);
    tbl[8]  = mk(0,0,0,      1,7,16'h0777,0, 0,1,1, 3,16'hABCD,16'd1);
    tbl[9]  = mk(0,0,0,      0,0,0,      0, 0,0,1, 7,16'h0777,16'd2);
    tbl[10] = mk(0,0,0,      0,0,0,      0, 0,0,0, 7,16'h0777,16'd3);
    tbl[11] = mk(1,0,16'hBEEF,0,0,0,     0, 1,0,0, 7,16'h0777,16'd3);
    tbl[12] = mk(0,0,0,      0,0,0,      0, 0,0,1, 0,16'hBEEF,16'd3);
    tbl[13] = mk(0,0,0,      0,0,0,      0, 0,0,0, 0,16'hBEEF,16'd4);

    // Reset state with both requesters asserting: nothing may be granted.
    rst_n = 1'b0;
    drive(1, 1, 16'h1111, 1, 2, 16'h2222, 0);
    #3;
    chk("reset_outputs",
        {req0_ready, req1_ready, RegWrite, write_reg, write_data, wb_count},
        {1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0});
    do_reset();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].g0, tbl[i].d0,
            tbl[i].v1, tbl[i].g1, tbl[i].d1, tbl[i].st);
      #1;
      chk($sformatf("vec%0d", i),
          {req0_ready, req1_ready, RegWrite, write_reg, write_data, wb_count},
          {tbl[i].r0, tbl[i].r1, tbl[i].rw, tbl[i].wr, tbl[i].wd, tbl[i].cnt});
    end

    // Contention: both requesters valid every cycle.
    do_reset();
    drive(1, 1, 16'h1111, 1, 2, 16'h2222, 0);
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef REGFILE_WB_ARB_RR_EN
      e0  = (k % 2 == 0);
      e1  = (k % 2 == 1);
      ewr = (k == 0) ? 3'd0 : (((k - 1) % 2 == 0) ? 3'd1 : 3'd2);
      ewd = (k == 0) ? 16'd0 : (((k - 1) % 2 == 0) ? 16'h1111 : 16'h2222);
`else
      e0  = 1'b0;
      e1  = 1'b1;
      ewr = (k == 0) ? 3'd0 : 3'd2;
      ewd = (k == 0) ? 16'd0 : 16'h2222;
`endif
      chk($sformatf("contend%0d", k),
          {req0_ready, req1_ready, RegWrite, write_reg, write_data},
          {e0, e1, (k > 0) ? 1'b1 : 1'b0, ewr, ewd});
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("contend_count", {48'd0, wb_count}, 64'd7);

    // Same-register race; requesters drop valid once accepted.
    do_reset();
    for (int r = 0; r < 8; r++) rf[r] = 16'd0;
    commits.delete();
    drive(1, 5, 16'h0005, 1, 5, 16'h0050, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      if (RegWrite) begin
        commits.push_back(write_data);
        rf[write_reg] = write_data;
      end
      a0 = req0_ready;
      a1 = req1_ready;
      @(negedge clk);
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    c0 = (commits.size() > 0) ? commits[0] : 16'hDEAD;
    c1 = (commits.size() > 1) ? commits[1] : 16'hDEAD;
    chk("race_ncommit", 64'(commits.size()), 64'd2);
`ifdef REGFILE_WB_ARB_RR_EN
    chk("race_first", {48'd0, c0}, 64'h0005);
    chk("race_second", {48'd0, c1}, 64'h0050);
    chk("race_rf5", {48'd0, rf[5]}, 64'h0050);
`else
    chk("race_first", {48'd0, c0}, 64'h0050);
    chk("race_second", {48'd0, c1}, 64'h0005);
    chk("race_rf5", {48'd0, rf[5]}, 64'h0005);
`endif

    // Reset between accept and commit discards the entry.
    do_reset();
    drive(1, 6, 16'h7777, 0, 0, 0, 0);
    #1;
    chk("midrst_accept", {63'd0, req0_ready}, 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_during",
        {RegWrite, req0_ready, req1_ready, write_reg, write_data, wb_count},
        {1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0});
    @(posedge clk);
    #1;
    chk("midrst_edge", {63'd0, RegWrite}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2, 16'h1234, 0, 0, 0, 0);
    #1;
    chk("midrst_after",
        {RegWrite, req0_ready, write_reg, write_data, wb_count},
        {1'b0, 1'b1, 3'd0, 16'd0, 16'd0});
    @(posedge clk);
    #1;
    chk("first_accept",
        {RegWrite, write_reg, write_data},
        {1'b1, 3'd2, 16'h1234});

    // Counter wrap: 0xFFFF back-to-back commits, then one more.
    do_reset();
    drive(1, 1, 16'h00AA, 0, 0, 0, 0);
    repeat (65536) @(posedge clk);
    #1;
    chk("wrap_ffff", {RegWrite, wb_count}, {1'b1, 16'hFFFF});
    @(posedge clk);
    #1;
    chk("wrap_zero", {48'd0, wb_count}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
